div_const_pipe: RTL and testbench

Pipelined, parametrised unsigned divider by a compile-time constant. It generalises the fixed 32-by-11 combinational divider in width, divisor and digit size. It processes K dividend bits per stage with a remainder recurrence, accepts one operand per cycle through a valid/ready handshake, and collapses bubbles under backpressure. It sits wherever datapath code needs a constant division and can absorb a few cycles of latency.

---
 rtl/div_const_pkg.sv | 30 +++
 rtl/div_const_stage.sv | 105 ++++++++++
 rtl/div_const_pipe.sv | 94 +++++++++
 tb/tb_div_const_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_const_pkg.sv
// div_const_pkg: shared helpers for the constant-divisor pipeline.
//   clog2        - ceiling log2, sizes the remainder
//   stage_cnt    - ceil(w/k), the number of digit stages
//   digit_divmod - {quotient[15:8], remainder[7:0]} of t/d; used to build the
//                  per-stage lookup table as an elaboration-time constant
//   params_ok    - legal range of WIDTH / DIVISOR / K
package div_const_pkg;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int stage_cnt(input int w, input int k);
    return (w + k - 1) / k;
  endfunction

  function automatic logic [15:0] digit_divmod(input int t, input int d);
    logic [7:0] q, r;
    q = 8'(t / d);
    r = 8'(t % d);
    return {q, r};
  endfunction

  function automatic bit params_ok(input int w, input int d, input int k);
    return (w >= 8) && (w <= 64) && (d >= 2) && (d <= 255) && (k >= 1) && (k <= 6);
  endfunction

endpackage

// File: rtl/div_const_stage.sv
// div_const_stage: one digit stage of the constant divider.
//   Takes the previous stage's remainder and the top K bits of the remaining
//   dividend, looks up {digit quotient, digit remainder} in a constant table,
//   and registers the shifted dividend, the grown quotient and the tag.
// Ports:
//   clk, rst_n, clr        clock, async active-low reset, sync valid flush
//   nxt_load / load        ready chain: this stage loads when empty or when the
//                          next stage loads
//   prv_*                  registers of the previous stage (or the input side)
//   v, rem, dig, quo, tag  this stage's registers
// KEEP_R = 0 drops the remainder register (rem reads as 0).
module div_const_stage
  import div_const_pkg::*;
#(
  parameter int DIVISOR = 11,
  parameter int K       = 4,
  parameter int RW      = 4,
  parameter int SK      = 32,
  parameter int TAG_W   = 4,
  parameter bit KEEP_R  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             nxt_load,
  output logic             load,
  input  logic             prv_v,
  input  logic [RW-1:0]    prv_rem,
  input  logic [SK-1:0]    prv_dig,
  input  logic [SK-1:0]    prv_quo,
  input  logic [TAG_W-1:0] prv_tag,
  output logic             v,
  output logic [RW-1:0]    rem,
  output logic [SK-1:0]    dig,
  output logic [SK-1:0]    quo,
  output logic [TAG_W-1:0] tag
);

  // Only r < DIVISOR is reachable, so DIVISOR*2^K entries cover every t and
  // the index width clog2(DIVISOR*2^K) equals RW+K.
  localparam int TN = DIVISOR << K;

  logic [K+RW-1:0] tbl [TN];
  for (genvar i = 0; i < TN; i++) begin : g_tbl
    localparam logic [15:0] E = digit_divmod(i, DIVISOR);
    assign tbl[i] = {E[8 +: K], E[0 +: RW]};
  end

  logic [RW+K-1:0] t;
  logic [K+RW-1:0] ent;
  assign t   = {prv_rem, prv_dig[SK-1 -: K]};
  assign ent = tbl[t];

  logic             v_d, v_q;
  logic [SK-1:0]    dig_d, dig_q, quo_d, quo_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  assign load = !v_q || nxt_load;

  always_comb begin
    v_d   = v_q;
    dig_d = dig_q;
    quo_d = quo_q;
    tag_d = tag_q;
    if (load) begin
      v_d   = prv_v;
      dig_d = prv_dig << K;
      quo_d = (prv_quo << K) | SK'(ent[RW +: K]);
      tag_d = prv_tag;
    end
    if (clr) v_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      dig_q <= '0;
      quo_q <= '0;
      tag_q <= '0;
    end else begin
      v_q   <= v_d;
      dig_q <= dig_d;
      quo_q <= quo_d;
      tag_q <= tag_d;
    end
  end

  if (KEEP_R) begin : g_rem
    logic [RW-1:0] rem_d, rem_q;
    always_comb rem_d = load ? ent[RW-1:0] : rem_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rem_q <= '0;
      else        rem_q <= rem_d;
    end
    assign rem = rem_q;
  end else begin : g_no_rem
    assign rem = '0;
  end

  assign v   = v_q;
  assign dig = dig_q;
  assign quo = quo_q;
  assign tag = tag_q;

endmodule

// File: rtl/div_const_pipe.sv
// div_const_pipe: pipelined unsigned divide by a compile-time constant.
//   K dividend bits per stage, S = ceil(WIDTH/K) stages, valid/ready on both
//   sides with bubble collapse, tag carried alongside each operand.
// Ports:
//   clk, rst_n (async, active low), clr (sync flush of in-flight operands)
//   in_valid/in_ready/in_x/in_tag     operand side
//   out_valid/out_ready/out_q/out_r/out_tag  result side
// Macro DIV_CONST_PIPE_REM_EN: when defined, out_r carries in_x mod DIVISOR;
// otherwise out_r is 0 and the last remainder register is not built.
module div_const_pipe
  import div_const_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIVISOR = 11,
  parameter int K       = 4,
  parameter int TAG_W   = 4,
  localparam int RW     = clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [RW-1:0]    out_r,
  output logic [TAG_W-1:0] out_tag
);

  localparam int S  = stage_cnt(WIDTH, K);
  localparam int SK = S * K;
`ifdef DIV_CONST_PIPE_REM_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  if (!params_ok(WIDTH, DIVISOR, K)) begin : g_bad_params
    $error("div_const_pipe: need WIDTH 8..64, DIVISOR 2..255, K 1..6");
  end

  // Index 0 is the input side; index j is stage j.
  logic [S:0]             v;
  logic [S:0][RW-1:0]     r;
  logic [S:0][SK-1:0]     dig, quo;
  logic [S:0][TAG_W-1:0]  tag;
  logic [S+1:1]           ld;

  assign v[0]     = in_valid;
  assign r[0]     = '0;
  assign dig[0]   = SK'(in_x);  // zero-extend to S*K bits
  assign quo[0]   = '0;
  assign tag[0]   = in_tag;
  assign ld[S+1]  = out_ready;

  for (genvar j = 1; j <= S; j++) begin : g_stg
    div_const_stage #(
      .DIVISOR (DIVISOR),
      .K       (K),
      .RW      (RW),
      .SK      (SK),
      .TAG_W   (TAG_W),
      .KEEP_R  ((j < S) || REM_EN)
    ) u_stg (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .nxt_load (ld[j+1]),
      .load     (ld[j]),
      .prv_v    (v[j-1]),
      .prv_rem  (r[j-1]),
      .prv_dig  (dig[j-1]),
      .prv_quo  (quo[j-1]),
      .prv_tag  (tag[j-1]),
      .v        (v[j]),
      .rem      (r[j]),
      .dig      (dig[j]),
      .quo      (quo[j]),
      .tag      (tag[j])
    );
  end

  // Stage 1 clears its valid under clr anyway; gating here tells the source
  // the operand was not taken.
  assign in_ready  = ld[1] && !clr;
  assign out_valid = v[S];
  assign out_q     = quo[S][WIDTH-1:0];
  assign out_r     = r[S];
  assign out_tag   = tag[S];

endmodule

// File: tb/tb_div_const_pipe.sv
module tb_div_const_pipe;

`ifdef DIV_CONST_PIPE_REM_EN
  localparam bit REM = 1'b1;
`else
  localparam bit REM = 1'b0;
`endif

  typedef struct {
    logic [31:0] q;
    logic [7:0]  r;
    logic [3:0]  tag;
    int          lat;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;

  // main instance: defaults (WIDTH 32, DIVISOR 11, K 4)
  logic        in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [31:0] in_x = '0, out_q;
  logic [3:0]  in_tag = '0, out_r, out_tag;

  // second instance: WIDTH 16, DIVISOR 7, K 3
  logic        in_valid2 = 1'b0, out_ready2 = 1'b1, in_ready2, out_valid2;
  logic [15:0] in_x2 = '0, out_q2;
  logic [3:0]  in_tag2 = '0, out_tag2;
  logic [2:0]  out_r2;

  div_const_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r), .out_tag(out_tag)
  );

  div_const_pipe #(.WIDTH(16), .DIVISOR(7), .K(3), .TAG_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_x(in_x2), .in_tag(in_tag2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_q(out_q2), .out_r(out_r2), .out_tag(out_tag2)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_acc = 0, n_del = 0, first_del = -1, last_del = -1;
  exp_t sb[$], sb2[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Call at a negedge; returns at a negedge after the operand is accepted.
  task automatic send(input logic [31:0] x, input logic [3:0] t,
                      input logic [31:0] q, input logic [3:0] r, input bit lat);
    exp_t e;
    in_valid = 1'b1; in_x = x; in_tag = t;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (in_ready) begin
        e.q = q; e.r = REM ? 8'(r) : 8'd0; e.tag = t; e.lat = lat ? cyc : -1;
        sb.push_back(e);
        n_acc++;
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [15:0] x, input logic [3:0] t,
                       input logic [15:0] q, input logic [2:0] r);
    exp_t e;
    in_valid2 = 1'b1; in_x2 = x; in_tag2 = t;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (in_ready2) begin
        e.q = 32'(q); e.r = REM ? 8'(r) : 8'd0; e.tag = t; e.lat = -1;
        sb2.push_back(e);
        @(negedge clk);
        in_valid2 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("send2_timeout", 0, 1);
    in_valid2 = 1'b0;
  endtask

  task automatic drain(input int which);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #3;
      if ((which == 1 ? sb.size() : sb2.size()) == 0) break;
    end
    chk(which == 1 ? "drain" : "drain2", which == 1 ? sb.size() : sb2.size(), 0);
    @(negedge clk);
  endtask

  // monitors: compare whenever a result is handed over
  initial forever begin
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", out_q, 32'hDEAD);
      else begin
        e = sb.pop_front();
        chk("out_q", out_q, e.q);
        chk("out_r", out_r, e.r);
        chk("out_tag", out_tag, e.tag);
        if (e.lat >= 0) chk("latency", cyc - e.lat, 8);
      end
      n_del++;
      if (first_del < 0) first_del = cyc;
      last_del = cyc;
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && out_valid2 && out_ready2) begin
      if (sb2.size() == 0) chk("unexpected_out2", out_q2, 32'hDEAD);
      else begin
        e = sb2.pop_front();
        chk("out_q2", out_q2, e.q);
        chk("out_r2", out_r2, e.r);
        chk("out_tag2", out_tag2, e.tag);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // basic vectors, latency on the first
    send(32'd1000, 4'd3, 32'd90, 4'd10, 1'b1);
    send(32'hFFFF_FFFF, 4'd5, 32'd390451572, 4'd3, 1'b0);
    send(32'd0, 4'd6, 32'd0, 4'd0, 1'b0);
    drain(1);

    // ten back-to-back operands 0..9
    first_del = -1; d0 = n_del;
    for (int i = 0; i < 10; i++) send(32'(i), 4'(i), 32'd0, 4'(i), 1'b0);
    drain(1);
    chk("b2b_count", n_del - d0, 10);
    chk("b2b_span", last_del - first_del, 9);

    // backpressure: out_ready low for 12 cycles
    out_ready = 1'b0; d0 = n_acc;
    fork
      for (int i = 0; i < 10; i++) send(32'(11 * (50 + i) + i), 4'(i), 32'(50 + i), 4'(i), 1'b0);
      begin
        repeat (10) @(negedge clk);
        #1 chk("bp_hold_q_a", out_q, 50);
        repeat (2) @(negedge clk);
        #1;
        chk("bp_hold_q_b", out_q, 50);
        chk("bp_hold_tag", out_tag, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_accepts", n_acc - d0, 8);
        chk("bp_in_ready", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain(1);

    // clr with 5 operands in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'(11 * i + 1), 4'(i), 32'(i), 4'd1, 1'b0);
    repeat (8) @(negedge clk);
    #1 chk("pre_clr_valid", out_valid, 1);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_x = 32'd5; in_tag = 4'd15;
    #1 chk("clr_in_ready", in_ready, 0);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    #1 chk("clr_flush", out_valid, 0);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    send(32'd22, 4'd7, 32'd2, 4'd0, 1'b0);
    drain(1);
    repeat (10) @(negedge clk);

    // async reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'(100 + i), 4'(i + 1), 32'd9, 4'(1 + i), 1'b0);
    repeat (8) @(negedge clk);
    #1 chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_q", out_q, 0);
    chk("mid_rst_tag", out_tag, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
    send(32'd121, 4'd9, 32'd11, 4'd0, 1'b0);
    drain(1);
    repeat (10) @(negedge clk);

    // second configuration
    send2(16'd121, 4'd1, 16'd17, 3'd2);
    send2(16'hFFFF, 4'd2, 16'd9362, 3'd1);
    send2(16'd0, 4'd3, 16'd0, 3'd0);
    send2(16'd1000, 4'd4, 16'd142, 3'd6);
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
